// File: rtl/main_memory_pkg.sv
// Shared types and helpers for the line-granular backing store.
package main_memory_pkg;

    // Controller states: idle, counting down a read/write, then waiting for the request to drop.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        WR_WAIT = 3'd2,
        RD_DONE = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    localparam int LINE_BYTES = 4;
    localparam int LINE_W     = 8 * LINE_BYTES;

    // Power-on/reset image: the byte at address a holds a (mod 256), byte0 in the low lane.
    function automatic logic [LINE_W-1:0] init_word(input int idx);
        logic [LINE_W-1:0] w;
        w = '0;
        for (int b = 0; b < LINE_BYTES; b++) begin
            w[8*b +: 8] = 8'((idx * LINE_BYTES + b) % 256);
        end
        return w;
    endfunction

endpackage

// File: rtl/main_memory_if.sv
// Memory-side bus between the cache (master) and the backing store (slave).
// Handshake: MRead_request / MWrite_request are levels held by the master until it sees
// the matching one-cycle ready pulse, then dropped; the slave serves a request only once
// per assertion, and MRead_data stays valid from the MRead_ready pulse until the next read.
interface main_memory_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32
);
    logic                  MRead_request;
    logic                  MWrite_request;
    logic [ADDR_WIDTH-1:0] MAddress;
    logic [LINE_WIDTH-1:0] MWrite_data;
    logic                  MRead_ready;
    logic                  MWrite_ready;
    logic [LINE_WIDTH-1:0] MRead_data;

    modport master (
        output MRead_request, MWrite_request, MAddress, MWrite_data,
        input  MRead_ready, MWrite_ready, MRead_data
    );

    modport slave (
        input  MRead_request, MWrite_request, MAddress, MWrite_data,
        output MRead_ready, MWrite_ready, MRead_data
    );
endinterface

// File: rtl/main_memory_array.sv
// Line storage: synchronous write, registered read, whole array reloaded on reset.
module main_memory_array
    import main_memory_pkg::*;
#(
    parameter int IDX_WIDTH  = 6,
    parameter int LINE_WIDTH = LINE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [LINE_WIDTH-1:0] wdata,
    output logic [LINE_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << IDX_WIDTH;

    logic [LINE_WIDTH-1:0] mem [DEPTH];

    // Reset reloads the known image and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= LINE_WIDTH'(init_word(i));
            end
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

    // Read port register holds its value until the next read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end
endmodule

// File: rtl/main_memory.sv
// Fixed-latency backing store: FSM, latency counter and request latches around the line array.
module main_memory
    import main_memory_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int LINE_WIDTH    = 32,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    main_memory_if.slave bus,
    output state_t       dbg_state
);
    localparam int IDX_WIDTH = ADDR_WIDTH - 2;
    localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W     = $clog2(MAX_LAT + 1);

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [IDX_WIDTH-1:0]  idx_q, idx_next;
    logic [LINE_WIDTH-1:0] data_q, data_next;
    logic                  rd_fire, wr_fire;
    logic                  rd_ready_q, wr_ready_q;
    logic [LINE_WIDTH-1:0] arr_rdata;

    // Byte-offset bits select nothing in a line-granular store.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^bus.MAddress[1:0];

    // Next-state logic: write-back beats fill in IDLE; DONE states wait for the served request to drop.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx_q;
        data_next  = data_q;
        rd_fire    = 1'b0;
        wr_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.MWrite_request) begin
                    idx_next   = bus.MAddress[ADDR_WIDTH-1:2];
                    data_next  = bus.MWrite_data;
                    cnt_next   = CNT_W'(WRITE_LATENCY - 1);
                    state_next = WR_WAIT;
                end else if (bus.MRead_request) begin
                    idx_next   = bus.MAddress[ADDR_WIDTH-1:2];
                    cnt_next   = CNT_W'(READ_LATENCY - 1);
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    rd_fire    = 1'b1;
                    state_next = RD_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            WR_WAIT: begin
                if (cnt == '0) begin
                    wr_fire    = 1'b1;
                    state_next = WR_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            RD_DONE: begin
                if (!bus.MRead_request) state_next = IDLE;
            end
            WR_DONE: begin
                if (!bus.MWrite_request) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counter, latches and the one-cycle ready pulses; reset aborts any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            rd_ready_q <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx_q      <= idx_next;
            data_q     <= data_next;
            rd_ready_q <= rd_fire;
            wr_ready_q <= wr_fire;
        end
    end

    main_memory_array #(
        .IDX_WIDTH  (IDX_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .re    (rd_fire),
        .idx   (idx_q),
        .wdata (data_q),
        .rdata (arr_rdata)
    );

    assign bus.MRead_ready  = rd_ready_q;
    assign bus.MWrite_ready = wr_ready_q;
    assign bus.MRead_data   = arr_rdata;
    assign dbg_state        = state;
endmodule

// File: tb/tb_main_memory.sv
// Bench for main_memory: two builds (latency 4/4 and 1/7) against a byte-addressed model.
module tb_main_memory;
    import main_memory_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b0;
    state_t a_state, b_state;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ref_mem [2][256];
    logic [31:0] exp_q[$];

    main_memory_if #(.ADDR_WIDTH(8), .LINE_WIDTH(32)) a_if ();
    main_memory_if #(.ADDR_WIDTH(8), .LINE_WIDTH(32)) b_if ();

    main_memory #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut_a (
        .clk(clk), .rst(rst), .bus(a_if.slave), .dbg_state(a_state)
    );
    main_memory #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .READ_LATENCY(1), .WRITE_LATENCY(7)) dut_b (
        .clk(clk), .rst(rst), .bus(b_if.slave), .dbg_state(b_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int rd_lat(input int w);
        return (w == 0) ? 4 : 1;
    endfunction

    function automatic int wr_lat(input int w);
        return (w == 0) ? 4 : 7;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++)
            for (int a = 0; a < 256; a++)
                ref_mem[w][a] = 8'(a);
    endtask

    function automatic logic [31:0] model_line(input int w, input logic [7:0] addr);
        int base;
        base = int'(addr) & 'hFC;
        return {ref_mem[w][base+3], ref_mem[w][base+2], ref_mem[w][base+1], ref_mem[w][base]};
    endfunction

    task automatic model_write(input int w, input logic [7:0] addr, input logic [31:0] d);
        int base;
        base = int'(addr) & 'hFC;
        for (int b = 0; b < 4; b++) ref_mem[w][base+b] = d[8*b +: 8];
    endtask

    // ---------------- driver helpers ----------------
    task automatic drive(input int w, input logic rq, input logic wq,
                         input logic [7:0] ad, input logic [31:0] wd);
        if (w == 0) begin
            a_if.MRead_request = rq; a_if.MWrite_request = wq;
            a_if.MAddress = ad;      a_if.MWrite_data = wd;
        end else begin
            b_if.MRead_request = rq; b_if.MWrite_request = wq;
            b_if.MAddress = ad;      b_if.MWrite_data = wd;
        end
    endtask

    function automatic logic get_rrdy(input int w);
        return (w == 0) ? a_if.MRead_ready : b_if.MRead_ready;
    endfunction

    function automatic logic get_wrdy(input int w);
        return (w == 0) ? a_if.MWrite_ready : b_if.MWrite_ready;
    endfunction

    function automatic logic [31:0] get_rdata(input int w);
        return (w == 0) ? a_if.MRead_data : b_if.MRead_data;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
    endtask

    // Entered and left on a negedge with the DUT idle. Address is scrambled once accepted.
    task automatic read_txn(input int w, input logic [7:0] addr, input int hold);
        int n;
        logic seen;
        logic [31:0] exp;
        exp_q.push_back(model_line(w, addr));
        drive(w, 1'b1, 1'b0, addr, $urandom);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (get_rrdy(w)) seen = 1'b1;
            else drive(w, 1'b1, 1'b0, 8'($urandom_range(0, 255)), $urandom);
        end
        exp = exp_q.pop_front();
        check("rd_ready_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("rd_latency", 32'(n - 1), 32'(rd_lat(w)));
            check("rd_data", get_rdata(w), exp);
        end
        for (int i = 0; i < hold + 1; i++) begin
            @(negedge clk);
            check("rd_single_pulse", 32'(get_rrdy(w)), 32'd0);
            check("rd_data_held", get_rdata(w), exp);
        end
        drive(w, 1'b0, 1'b0, 8'($urandom_range(0, 255)), $urandom);
        @(negedge clk);
    endtask

    task automatic write_txn(input int w, input logic [7:0] addr, input logic [31:0] d, input int hold);
        int n;
        logic seen;
        drive(w, 1'b0, 1'b1, addr, d);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (get_wrdy(w)) seen = 1'b1;
            else drive(w, 1'b0, 1'b1, 8'($urandom_range(0, 255)), $urandom);
        end
        check("wr_ready_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("wr_latency", 32'(n - 1), 32'(wr_lat(w)));
            model_write(w, addr, d);
        end
        for (int i = 0; i < hold + 1; i++) begin
            @(negedge clk);
            check("wr_single_pulse", 32'(get_wrdy(w)), 32'd0);
        end
        drive(w, 1'b0, 1'b0, 8'($urandom_range(0, 255)), $urandom);
        @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic seen;
        drive(0, 1'b0, 1'b0, 8'h00, 32'h0);
        drive(1, 1'b0, 1'b0, 8'h00, 32'h0);
        model_reset();

        // Reset state
        apply_reset();
        check("rst_rd_ready", 32'(a_if.MRead_ready), 32'd0);
        check("rst_wr_ready", 32'(a_if.MWrite_ready), 32'd0);
        check("rst_rd_data", a_if.MRead_data, 32'h0);
        check("rst_state", 32'(a_state), 32'(IDLE));
        check("rst_b_rd_data", b_if.MRead_data, 32'h0);

        // Init image and default read latency
        read_txn(0, 8'd3, 0);
        check("t1_init_data", a_if.MRead_data, 32'h03020100);

        // Write then read back through an aliasing address
        write_txn(0, 8'd8, 32'hDEADBEEF, 0);
        read_txn(0, 8'd9, 0);
        check("t2_alias_data", a_if.MRead_data, 32'hDEADBEEF);

        // Simultaneous requests: write first, read served afterwards
        drive(0, 1'b1, 1'b1, 8'd8, 32'h5A5A1234);
        n = 0; seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (a_if.MWrite_ready) seen = 1'b1;
            else check("t3_no_early_read", 32'(a_if.MRead_ready), 32'd0);
        end
        check("t3_wr_first", 32'(seen), 32'd1);
        check("t3_wr_latency", 32'(n - 1), 32'd4);
        check("t3_rd_not_yet", 32'(a_if.MRead_ready), 32'd0);
        model_write(0, 8'd8, 32'h5A5A1234);
        drive(0, 1'b1, 1'b0, 8'd4, 32'h0);
        n = 0; seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (a_if.MRead_ready) seen = 1'b1;
        end
        check("t3_rd_served", 32'(seen), 32'd1);
        check("t3_rd_gap", 32'(n), 32'd6);
        check("t3_rd_data", a_if.MRead_data, model_line(0, 8'd4));
        drive(0, 1'b0, 1'b0, 8'd0, 32'h0);
        @(negedge clk);
        read_txn(0, 8'd8, 0);

        // Held request gives one pulse; re-raise is a new transaction
        read_txn(0, 8'd20, 3);
        read_txn(0, 8'd20, 0);

        // Reset while a write is in flight (counter at 1): no commit, no pulse
        drive(0, 1'b0, 1'b1, 8'd12, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_wr_pending", 32'(a_if.MWrite_ready), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 8'd0, 32'h0);
        model_reset();
        check("t5_no_wr_ready_rst", 32'(a_if.MWrite_ready), 32'd0);
        check("t5_state_idle", 32'(a_state), 32'(IDLE));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_wr_ready_after", 32'(a_if.MWrite_ready), 32'd0);
        end
        read_txn(0, 8'd12, 0);
        check("t5_not_committed", a_if.MRead_data, 32'h0F0E0D0C);

        // Short-read / long-write build with address scrambled mid-wait
        read_txn(1, 8'd16, 0);
        check("t6_init_data", b_if.MRead_data, 32'h13121110);
        write_txn(1, 8'd16, 32'hA5C3F00F, 1);
        read_txn(1, 8'd17, 0);
        check("t6_write_data", b_if.MRead_data, 32'hA5C3F00F);

        // Randomized traffic on both builds
        for (int t = 0; t < 60; t++) begin
            int w;
            logic [7:0] ad;
            w  = (t % 4 == 3) ? 1 : 0;
            ad = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1)
                write_txn(w, ad, $urandom, int'($urandom_range(0, 2)));
            else
                read_txn(w, ad, int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
